// File: rtl/ysyx_25020032_lsu_axi_master_if.sv
// AXI4 bus between the LSU master and its memory-side slave.
// The master drives the AR, AW and W channels and the R/B ready signals.
interface ysyx_25020032_lsu_axi_master_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ysyx_25020032_lsu_axi_master.sv
// Single-beat AXI4 master for the LSU: one outstanding read or write at a time,
// with a one-cycle completion pulse carrying read data and an error flag.
module ysyx_25020032_lsu_axi_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  ysyx_25020032_lsu_axi_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, AR, R, AWW, B} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  size_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done;
  logic        w_done;
  logic        unused_bits;

  // A channel counts as done once its valid has dropped or it handshakes this cycle.
  assign aw_done = !awvalid_q || axi.awready;
  assign w_done  = !wvalid_q  || axi.wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      size_q     <= 3'h0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            size_q    <= req_size;
            req_ready <= 1'b0;
            if (req_wen) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= AWW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= AR;
            end
          end
        end
        AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (axi.rvalid) begin
            rready_q   <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= axi.rdata;
            resp_err   <= axi.rresp[1] | (axi.rid != AXI_ID);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        AWW: begin
          if (axi.awready) awvalid_q <= 1'b0;
          if (axi.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= B;
          end
        end
        B: begin
          if (axi.bvalid) begin
            bready_q   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= axi.bresp[1] | (axi.bid != AXI_ID);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'h0;
  assign axi.arsize  = size_q;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'h0;
  assign axi.awsize  = size_q;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  // Single-beat bursts make rlast redundant; only the error bit of each resp matters.
  assign unused_bits = ^{axi.rlast, axi.rresp[0], axi.bresp[0]};

endmodule

// File: tb/tb_ysyx_25020032_lsu_axi_master.sv
// Randomized bench for the LSU AXI master: the bench plays the AXI slave with
// random stalls and predicts timing, bus fields and completions from a simple model.
module tb_ysyx_25020032_lsu_axi_master;
  localparam logic [3:0] AXI_ID_TB = 4'h0;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_chk;
  int n_err;
  logic [31:0] last_rdata;

  ysyx_25020032_lsu_axi_master_if axi ();

  ysyx_25020032_lsu_axi_master #(.AXI_ID(AXI_ID_TB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_size  (req_size),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .axi       (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current (idle) cycle; returns one cycle after acceptance.
  task automatic issue(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [2:0] sz);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = ws;
    req_size  = sz;
    tick();
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("resp_valid_one_cycle", 32'(resp_valid), 32'd0);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input int arw, input int rw,
                         input logic [31:0] rd, input logic [1:0] rr, input logic [3:0] id);
    logic e;
    issue(1'b0, a, 32'h0, 4'h0, sz);
    chk("arvalid_t1", 32'(axi.arvalid), 32'd1);
    chk("araddr", axi.araddr, a);
    chk("arsize", 32'(axi.arsize), 32'(sz));
    chk("arlen", 32'(axi.arlen), 32'd0);
    chk("arburst", 32'(axi.arburst), 32'd1);
    chk("arid", 32'(axi.arid), 32'(AXI_ID_TB));
    chk("awvalid_in_read", 32'(axi.awvalid), 32'd0);
    chk("rready_early", 32'(axi.rready), 32'd0);
    repeat (arw) begin
      tick();
      chk("arvalid_hold", 32'(axi.arvalid), 32'd1);
      chk("araddr_stable", axi.araddr, a);
      chk("req_ready_ar", 32'(req_ready), 32'd0);
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("arvalid_drop", 32'(axi.arvalid), 32'd0);
    chk("rready_up", 32'(axi.rready), 32'd1);
    repeat (rw) begin
      tick();
      chk("rready_hold", 32'(axi.rready), 32'd1);
      chk("resp_valid_early", 32'(resp_valid), 32'd0);
    end
    axi.rvalid = 1'b1;
    axi.rdata  = rd;
    axi.rresp  = rr;
    axi.rid    = id;
    axi.rlast  = 1'($urandom_range(0, 1));
    tick();
    axi.rvalid = 1'b0;
    axi.rdata  = $urandom;
    e = rr[1] | (id != AXI_ID_TB);
    last_rdata = rd;
    chk("rd_resp_valid", 32'(resp_valid), 32'd1);
    chk("rd_resp_rdata", resp_rdata, last_rdata);
    chk("rd_resp_err", 32'(resp_err), 32'(e));
    chk("rready_drop", 32'(axi.rready), 32'd0);
    chk("req_ready_resp", 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [2:0] sz, input int awd, input int wdd, input int bw,
                          input logic [1:0] br, input logic [3:0] id);
    int mx;
    logic e;
    issue(1'b1, a, wd, ws, sz);
    chk("awvalid_t1", 32'(axi.awvalid), 32'd1);
    chk("wvalid_t1", 32'(axi.wvalid), 32'd1);
    chk("awaddr", axi.awaddr, a);
    chk("wdata", axi.wdata, wd);
    chk("wstrb", 32'(axi.wstrb), 32'(ws));
    chk("awsize", 32'(axi.awsize), 32'(sz));
    chk("awlen", 32'(axi.awlen), 32'd0);
    chk("awburst", 32'(axi.awburst), 32'd1);
    chk("awid", 32'(axi.awid), 32'(AXI_ID_TB));
    chk("wlast", 32'(axi.wlast), 32'd1);
    chk("arvalid_in_write", 32'(axi.arvalid), 32'd0);
    mx = (awd > wdd) ? awd : wdd;
    for (int c = 0; c <= mx; c++) begin
      axi.awready = (c == awd);
      axi.wready  = (c == wdd);
      tick();
      chk("awvalid_track", 32'(axi.awvalid), 32'(c < awd));
      chk("wvalid_track", 32'(axi.wvalid), 32'(c < wdd));
      chk("bready_after_both", 32'(axi.bready), 32'(c >= mx));
    end
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    repeat (bw) begin
      tick();
      chk("bready_hold", 32'(axi.bready), 32'd1);
      chk("resp_valid_early_b", 32'(resp_valid), 32'd0);
    end
    axi.bvalid = 1'b1;
    axi.bresp  = br;
    axi.bid    = id;
    tick();
    axi.bvalid = 1'b0;
    e = br[1] | (id != AXI_ID_TB);
    chk("wr_resp_valid", 32'(resp_valid), 32'd1);
    chk("wr_resp_err", 32'(resp_err), 32'(e));
    chk("wr_resp_rdata_held", resp_rdata, last_rdata);
    chk("bready_drop", 32'(axi.bready), 32'd0);
    chk("req_ready_resp_b", 32'(req_ready), 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    last_rdata = 32'h0;
    rst = 1'b0;
    req_valid = 1'b0;
    req_wen = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    req_size = 3'h0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata = 32'h0;
    axi.rresp = 2'b00;
    axi.rid = 4'h0;
    axi.rlast = 1'b0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    axi.bresp = 2'b00;
    axi.bid = 4'h0;

    repeat (2) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst_rready", 32'(axi.rready), 32'd0);
    chk("rst_bready", 32'(axi.bready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_araddr", axi.araddr, 32'h0);
    chk("rst_wdata", axi.wdata, 32'h0);
    rst = 1'b1;
    tick();
    chk("idle_no_req", 32'(axi.arvalid | axi.awvalid), 32'd0);

    do_read(32'ha0000048, 3'd2, 0, 0, 32'h00001234, 2'b00, 4'h0);
    do_write(32'h80000004, 32'hdeadbeef, 4'hf, 3'd2, 2, 0, 0, 2'b00, 4'h0);
    do_write(32'h80000010, 32'h01020304, 4'h3, 3'd1, 0, 0, 1, 2'b10, 4'h0);
    do_read(32'h80000020, 3'd2, 0, 1, 32'hcafef00d, 2'b00, 4'h3);
    do_read(32'h80000100, 3'd0, 5, 0, 32'h000000a5, 2'b00, 4'h0);
    do_write(32'h80000200, 32'h11223344, 4'h1, 3'd0, 0, 3, 0, 2'b00, 4'h0);

    // Reset asserted mid-read: the pending beat must never produce a response.
    issue(1'b0, 32'h80000300, 32'h0, 4'h0, 3'd2);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("rst_case_in_r", 32'(axi.rready), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    last_rdata = 32'h0;
    chk("async_rst_rready", 32'(axi.rready), 32'd0);
    chk("async_rst_req_ready", 32'(req_ready), 32'd1);
    chk("async_rst_rdata", resp_rdata, 32'h0);
    tick();
    rst = 1'b1;
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h5555aaaa;
    axi.rid    = 4'h0;
    axi.rresp  = 2'b00;
    repeat (2) begin
      tick();
      chk("late_rvalid_no_resp", 32'(resp_valid), 32'd0);
      chk("late_rvalid_rready", 32'(axi.rready), 32'd0);
      chk("late_rvalid_idle", 32'(req_ready), 32'd1);
    end
    axi.rvalid = 1'b0;

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      logic [3:0]  rid_v;
      ra = $urandom;
      rid_v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : AXI_ID_TB;
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rid_v);
      else
        do_read(ra, 3'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)), rid_v);
    end
    tick();
    chk("final_resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("final_idle", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
